seg_display_ctrl: RTL and testbench

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

---
 rtl/seg_display_ctrl_if.sv | 12 +
 rtl/seg_display_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_seg_display_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_display_ctrl_if.sv
// seg_display_ctrl_if
// Byte stream from the upstream SPI receiver into the display controller.
//   rx_valid : one-cycle strobe, a new byte is present on rx_data
//   rx_data  : received byte, meaningful only while rx_valid=1
// Modports: master (byte source), slave (seg_display_ctrl).
interface seg_display_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;

  modport master (output rx_valid, output rx_data);
  modport slave  (input  rx_valid, input  rx_data);
endinterface

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl
// Four-digit multiplexed 7-segment display controller. Two-byte frames
// (command, data) arriving from an SPI receiver write four digit registers
// or a control register; a scan engine time-multiplexes the digits.
//
// Parameters:
//   SCAN_DIV      clk cycles per digit slot (2..65535)
//   FRAME_TIMEOUT max clk cycles allowed between command and data byte
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   rx        seg_display_ctrl_if.slave (rx_valid, rx_data)
//   seg       registered segment drive {dp,g,f,e,d,c,b,a}, active-high
//   dig_en    registered digit enable, one-hot or zero, active-high
//   frame_err one-cycle pulse on rejected command or data timeout
// Build option:
//   SEG_HEX_DECODE_EN  digit registers hold hex nibble + dp instead of raw
//                      segment patterns.
//
// Commands: 8'b0100_00nn = write digit nn, 8'h80 = write control register.
// Control register: bit0 display enable, bits[7:4] per-digit blanking mask.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a command byte
// WAIT_DATA | command accepted, waiting for its data byte (timeout armed)
module seg_display_ctrl #(
  parameter int SCAN_DIV      = 1000,
  parameter int FRAME_TIMEOUT = 4095
) (
  input  logic                clk,
  input  logic                rst_n,
  seg_display_ctrl_if.slave   rx,
  output logic [7:0]          seg,
  output logic [3:0]          dig_en,
  output logic                frame_err
);

  localparam int TW = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT + 1) : 1;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_DATA = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic          wr_en;
  logic          tgt_load;
  logic          fe_nxt;
  logic          cmd_ok;
  logic          tgt_ctrl;
  logic [1:0]    tgt_dig;

  logic [7:0]    dig_reg [4];
  logic          disp_en;
  logic [3:0]    blank_mask;

  logic [15:0]   pre_cnt, pre_nxt;
  logic [1:0]    idx, idx_nxt;
  logic          pre_wrap;
  logic [7:0]    cur_pat;
  logic          show;

  assign cmd_ok = (rx.rx_data[7:2] == 6'b0100_00) || (rx.rx_data == 8'h80);

  // Frame decoder. The timeout counter is loaded on command accept and
  // counts down; data arriving in the terminal cycle still wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      to_cnt <= '0;
    end else begin
      state  <= state_nxt;
      to_cnt <= to_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    to_nxt    = to_cnt;
    wr_en     = 1'b0;
    tgt_load  = 1'b0;
    fe_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (rx.rx_valid) begin
          if (cmd_ok) begin
            state_nxt = WAIT_DATA;
            to_nxt    = TW'(FRAME_TIMEOUT - 1);
            tgt_load  = 1'b1;
          end else begin
            fe_nxt = 1'b1;
          end
        end
      end
      WAIT_DATA: begin
        if (rx.rx_valid) begin
          wr_en     = 1'b1;
          state_nxt = IDLE;
          to_nxt    = '0;
        end else if (to_cnt == '0) begin
          state_nxt = IDLE;
          fe_nxt    = 1'b1;
        end else begin
          to_nxt = to_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        to_nxt    = '0;
      end
    endcase
  end

  // Target latch and register file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tgt_ctrl   <= 1'b0;
      tgt_dig    <= 2'd0;
      dig_reg[0] <= 8'h00;
      dig_reg[1] <= 8'h00;
      dig_reg[2] <= 8'h00;
      dig_reg[3] <= 8'h00;
      disp_en    <= 1'b1;
      blank_mask <= 4'h0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= fe_nxt;
      if (tgt_load) begin
        tgt_ctrl <= (rx.rx_data == 8'h80);
        tgt_dig  <= rx.rx_data[1:0];
      end
      if (wr_en) begin
        if (tgt_ctrl) begin
          disp_en    <= rx.rx_data[0];
          blank_mask <= rx.rx_data[7:4];
        end else begin
          dig_reg[tgt_dig] <= rx.rx_data;
        end
      end
    end
  end

`ifdef SEG_HEX_DECODE_EN
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction
`endif

  // Scan engine. Outputs are registered from the next-cycle counter values
  // so that seg/dig_en line up with the prescaler: prescaler==0 is the
  // blank anti-ghosting cycle of each slot.
  assign pre_wrap = (pre_cnt == 16'(SCAN_DIV - 1));
  assign pre_nxt  = pre_wrap ? 16'd0 : pre_cnt + 16'd1;
  assign idx_nxt  = pre_wrap ? idx + 2'd1 : idx;
  assign show     = (pre_nxt != 16'd0) && disp_en && !blank_mask[idx_nxt];

`ifdef SEG_HEX_DECODE_EN
  assign cur_pat = {dig_reg[idx_nxt][7], hex_glyph(dig_reg[idx_nxt][3:0])};
`else
  assign cur_pat = dig_reg[idx_nxt];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= 16'd0;
      idx     <= 2'd0;
      seg     <= 8'h00;
      dig_en  <= 4'b0000;
    end else begin
      pre_cnt <= pre_nxt;
      idx     <= idx_nxt;
      seg     <= show ? cur_pat : 8'h00;
      dig_en  <= show ? (4'b0001 << idx_nxt) : 4'b0000;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
module tb_seg_display_ctrl;
  localparam int SD = 4;
  localparam int FT = 12;

  logic       clk;
  logic       rst_n;
  logic [7:0] seg;
  logic [3:0] dig_en;
  logic       frame_err;

  seg_display_ctrl_if rx_if ();

  seg_display_ctrl #(.SCAN_DIV(SD), .FRAME_TIMEOUT(FT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx_if),
    .seg       (seg),
    .dig_en    (dig_en),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: abstract frame state plus register contents and the
  // number of clock edges since reset release.
  logic [7:0] m_dig [4];
  logic       m_en;
  logic [3:0] m_mask;
  bit         m_pend;
  bit         m_pend_ctrl;
  int         m_pend_dig;
  int         m_age;
  int         m_n;
  int         m_quiet;

  function automatic logic [7:0] glyph(input logic [7:0] r);
`ifdef SEG_HEX_DECODE_EN
    logic [6:0] tbl [16];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return {r[7], tbl[r[3:0]]};
`else
    return r;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_display(input string tag);
    int p, i;
    logic [3:0] e_en;
    logic [7:0] e_seg;
    p = m_n % SD;
    i = (m_n / SD) % 4;
    if (p == 0 || !m_en || m_mask[i]) begin
      e_en  = 4'b0000;
      e_seg = 8'h00;
    end else begin
      e_en  = 4'(1 << i);
      e_seg = glyph(m_dig[i]);
    end
    check({tag, ".dig_en"}, {28'd0, dig_en}, {28'd0, e_en});
    check({tag, ".seg"}, {24'd0, seg}, {24'd0, e_seg});
  endtask

  // One clock cycle: drive optionally a byte, pass the rising edge, update
  // the model, and compare frame_err (always) and the display (once the
  // registers have been stable for a cycle).
  task automatic step(input bit v, input logic [7:0] b, input string tag);
    bit exp_fe;
    bit wrote;
    rx_if.rx_valid = v;
    rx_if.rx_data  = v ? b : 8'h00;
    @(negedge clk);
    rx_if.rx_valid = 1'b0;
    m_n++;
    exp_fe = 1'b0;
    wrote  = 1'b0;
    if (v) begin
      if (m_pend) begin
        wrote  = 1'b1;
        m_pend = 1'b0;
        if (m_pend_ctrl) begin
          m_en   = b[0];
          m_mask = b[7:4];
        end else begin
          m_dig[m_pend_dig] = b;
        end
      end else if (b[7:2] == 6'b010000) begin
        m_pend = 1'b1; m_pend_ctrl = 1'b0; m_pend_dig = int'(b[1:0]); m_age = 0;
      end else if (b == 8'h80) begin
        m_pend = 1'b1; m_pend_ctrl = 1'b1; m_age = 0;
      end else begin
        exp_fe = 1'b1;
      end
    end else if (m_pend) begin
      m_age++;
      if (m_age == FT) begin
        m_pend = 1'b0;
        exp_fe = 1'b1;
      end
    end
    check({tag, ".frame_err"}, {31'd0, frame_err}, {31'd0, exp_fe});
    if (m_quiet >= 1 && !wrote) check_display(tag);
    m_quiet = wrote ? 0 : m_quiet + 1;
  endtask

  task automatic idle(input int k, input string tag);
    for (int c = 0; c < k; c++) step(1'b0, 8'h00, tag);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    rx_if.rx_valid = 1'b1;
    rx_if.rx_data  = 8'h42;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check("reset.seg", {24'd0, seg}, 32'h0);
      check("reset.dig_en", {28'd0, dig_en}, 32'h0);
      check("reset.frame_err", {31'd0, frame_err}, 32'h0);
    end
    rx_if.rx_valid = 1'b0;
    rst_n = 1'b1;
    for (int d = 0; d < 4; d++) m_dig[d] = 8'h00;
    m_en = 1'b1; m_mask = 4'h0; m_pend = 1'b0; m_age = 0; m_n = 0; m_quiet = 1;
  endtask

  initial begin
    logic [7:0] b;
    rst_n = 1'b0;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'h00;
    @(negedge clk);
    do_reset(3);

    // Idle scan: blank cycle then three lit cycles per digit
    idle(3 * 4 * SD, "scan");

    // Digit 2 write
    step(1'b1, 8'h42, "d2cmd");
    step(1'b1, 8'h07, "d2data");
    idle(2 * 4 * SD, "d2scan");

    // Invalid command, then digit 0 write
    step(1'b1, 8'h55, "badcmd");
    step(1'b0, 8'h00, "badcmd_drop");
    step(1'b1, 8'h40, "d0cmd");
    step(1'b1, 8'h86, "d0data");
    idle(4 * SD, "d0scan");

    // Timeout, then 0x12 is a (bad) command
    step(1'b1, 8'h41, "tocmd");
    idle(FT, "towait");
    step(1'b1, 8'h12, "after_to");
    idle(4 * SD, "toscan");

    // Data in the terminal timeout cycle is accepted
    step(1'b1, 8'h41, "edgecmd");
    idle(FT - 1, "edgewait");
    step(1'b1, 8'h5B, "edgedata");
    idle(4 * SD + 2, "edgescan");

    // Blanking and display disable
    step(1'b1, 8'h80, "ctl1");
    step(1'b1, 8'h21, "ctl1d");
    idle(3 * 4 * SD, "blank1");
    step(1'b1, 8'h80, "ctl2");
    step(1'b1, 8'h00, "ctl2d");
    idle(2 * 4 * SD, "dark");
    step(1'b1, 8'h80, "ctl3");
    step(1'b1, 8'h01, "ctl3d");
    idle(4 * SD, "restore");

    // Reset in the middle of a frame
    step(1'b1, 8'h43, "rcmd");
    do_reset(1);
    step(1'b1, 8'h3F, "rdata_as_cmd");
    idle(2 * 4 * SD, "rscan");

    // Randomized frames, biased towards valid commands
    for (int k = 0; k < 120; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: b = 8'h40 | 8'($urandom_range(0, 3));
        5:             b = 8'h80;
        default:       b = 8'($urandom_range(0, 255));
      endcase
      step(1'b1, b, "rnd");
      if (m_pend) step(1'b1, 8'($urandom_range(0, 255)), "rnd_data");
      idle($urandom_range(0, 3), "rnd_gap");
      if ($urandom_range(0, 15) == 0) idle(4 * SD, "rnd_scan");
    end
    step(1'b1, 8'h80, "final_ctl");
    step(1'b1, 8'h01, "final_ctld");
    step(1'b1, 8'h41, "final_to");
    idle(FT + 4 * SD, "final_scan");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
